// File: rtl/dsp_bus_num_writeback_pkg.sv
// dsp_bus_num_writeback_pkg: constants and FSM state type shared by the DSP bus-number snooper and writeback blocks
package dsp_bus_num_writeback_pkg;
    localparam logic [9:0] PRI_BUS_NUM_REG_ADDR = 10'h6;
    localparam logic [3:0] PRI_BUS_BYTE_LANE    = 4'b0001;
    typedef enum logic [2:0] {
        WB_IDLE, WB_REQ, WB_WRITE, WB_READ, WB_CHECK, WB_DONE, WB_ERROR
    } wb_state_t;
endpackage

// File: rtl/dsp_bus_num_writeback.sv
// dsp_bus_num_writeback: writes the USP secondary bus number into the DSP primary bus number register and verifies it
module dsp_bus_num_writeback
    import dsp_bus_num_writeback_pkg::*;
#(
    parameter logic [15:0] FUNC_NUM       = 16'd0,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        dsp_user_clk,
    input  logic        sys_reset_n,
    input  logic        usp_bus_num_rdy_dsp_domain,
    input  logic [7:0]  usp_sec_bus,
    input  logic        wb_gnt,
    input  logic        dsp_cfg_mgmt_read_write_done,
    input  logic [31:0] dsp_cfg_mgmt_read_data,
    output logic        wb_req,
    output logic        dsp_cfg_mgmt_write,
    output logic        dsp_cfg_mgmt_read,
    output logic [9:0]  dsp_cfg_mgmt_addr,
    output logic [15:0] dsp_cfg_mgmt_function_number,
    output logic [31:0] dsp_cfg_mgmt_write_data,
    output logic [3:0]  dsp_cfg_mgmt_byte_enable,
    output logic        writeback_done,
    output logic        writeback_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int AW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    wb_state_t     state_q;
    logic [7:0]    target_q, rd_q;
    logic          valid_q, abort_q, write_q, read_q, req_q, done_q, err_q;
    logic [TW-1:0] tmo_q;
    logic [AW-1:0] att_q;
    logic          start, in_acc, tmo_hit, lost, quit, fail;
    logic          unused_rd_hi;

    assign unused_rd_hi = ^dsp_cfg_mgmt_read_data[31:8];
    assign start   = usp_bus_num_rdy_dsp_domain && (!valid_q || usp_sec_bus != target_q);
    assign in_acc  = state_q == WB_WRITE || state_q == WB_READ;
    assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES - 1);
    assign lost    = abort_q || !usp_bus_num_rdy_dsp_domain || !wb_gnt;
    assign quit    = in_acc && lost && (dsp_cfg_mgmt_read_write_done || tmo_hit);
    assign fail    = (in_acc && !dsp_cfg_mgmt_read_write_done && tmo_hit) ||
                     (state_q == WB_CHECK && rd_q != target_q);

    assign wb_req                       = req_q;
    assign dsp_cfg_mgmt_write           = write_q;
    assign dsp_cfg_mgmt_read            = read_q;
    assign dsp_cfg_mgmt_addr            = (write_q || read_q) ? PRI_BUS_NUM_REG_ADDR : '0;
    assign dsp_cfg_mgmt_function_number = (write_q || read_q) ? FUNC_NUM : '0;
    assign dsp_cfg_mgmt_write_data      = write_q ? {24'h0, target_q} : '0;
    assign dsp_cfg_mgmt_byte_enable     = write_q ? PRI_BUS_BYTE_LANE : '0;
    assign writeback_done               = done_q;
    assign writeback_error              = err_q;

    // Sequencer: latch target, arbitrate, write, read back, compare, retry; an in-flight access is never cut short
    always_ff @(posedge dsp_user_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q  <= WB_IDLE;
            target_q <= '0;
            rd_q     <= '0;
            valid_q  <= 1'b0;
            abort_q  <= 1'b0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
            att_q    <= '0;
        end else if (quit) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            state_q <= WB_IDLE;
        end else if (fail) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            if (att_q < AW'(MAX_RETRIES)) begin
                att_q   <= att_q + AW'(1);
                state_q <= WB_REQ;
            end else begin
                req_q   <= 1'b0;
                err_q   <= 1'b1;
                state_q <= WB_ERROR;
            end
        end else begin
            case (state_q)
                WB_IDLE, WB_DONE, WB_ERROR: if (start) begin
                    target_q <= usp_sec_bus;
                    valid_q  <= 1'b1;
                    att_q    <= '0;
                    done_q   <= 1'b0;
                    err_q    <= 1'b0;
                    req_q    <= 1'b1;
                    state_q  <= WB_REQ;
                end
                WB_REQ: if (!usp_bus_num_rdy_dsp_domain) begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= WB_IDLE;
                end else if (wb_gnt) begin
                    write_q <= 1'b1;
                    tmo_q   <= '0;
                    abort_q <= 1'b0;
                    state_q <= WB_WRITE;
                end
                WB_WRITE: begin
                    tmo_q   <= tmo_q + TW'(1);
                    abort_q <= lost;
                    if (dsp_cfg_mgmt_read_write_done) begin
                        write_q <= 1'b0;
                        read_q  <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= WB_READ;
                    end
                end
                WB_READ: begin
                    tmo_q   <= tmo_q + TW'(1);
                    abort_q <= lost;
                    if (dsp_cfg_mgmt_read_write_done) begin
                        read_q  <= 1'b0;
                        rd_q    <= dsp_cfg_mgmt_read_data[7:0];
                        state_q <= WB_CHECK;
                    end
                end
                WB_CHECK: begin
                    done_q  <= 1'b1;
                    req_q   <= 1'b0;
                    state_q <= WB_DONE;
                end
                default: state_q <= WB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp_bus_num_writeback.sv
// tb_dsp_bus_num_writeback: directed checks of DSP primary bus number writeback against a cfg_mgmt responder
module tb_dsp_bus_num_writeback;
    logic        dsp_user_clk = 1'b0;
    logic        sys_reset_n;
    logic        rdy;
    logic [7:0]  sec;
    logic        wb_gnt;
    logic        done_in;
    logic [31:0] read_data;
    logic        wb_req, wr, rd;
    logic [9:0]  addr;
    logic [15:0] fn;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        writeback_done, writeback_error;
    logic [66:0] all_outs;

    int          n_cmp = 0, n_bad = 0;
    int          n_wr, n_rd, wlen = 0, last_wlen = 0, cyc;
    logic [31:0] last_wdata;
    logic [3:0]  last_be, last_rd_be;
    logic [9:0]  last_addr;
    logic [15:0] last_fn;
    logic        both_seen = 1'b0;
    logic        rsp_en;
    int          lat;
    logic [7:0]  rd_def;
    logic [7:0]  rdq[$];

    dsp_bus_num_writeback #(.FUNC_NUM(16'h0003), .TIMEOUT_CYCLES(16), .MAX_RETRIES(3)) dut (
        .dsp_user_clk                (dsp_user_clk),
        .sys_reset_n                 (sys_reset_n),
        .usp_bus_num_rdy_dsp_domain  (rdy),
        .usp_sec_bus                 (sec),
        .wb_gnt                      (wb_gnt),
        .dsp_cfg_mgmt_read_write_done(done_in),
        .dsp_cfg_mgmt_read_data      (read_data),
        .wb_req                      (wb_req),
        .dsp_cfg_mgmt_write          (wr),
        .dsp_cfg_mgmt_read           (rd),
        .dsp_cfg_mgmt_addr           (addr),
        .dsp_cfg_mgmt_function_number(fn),
        .dsp_cfg_mgmt_write_data     (wdata),
        .dsp_cfg_mgmt_byte_enable    (be),
        .writeback_done              (writeback_done),
        .writeback_error             (writeback_error)
    );

    assign all_outs = {wb_req, wr, rd, addr, fn, wdata, be, writeback_done, writeback_error};

    always #5 dsp_user_clk = ~dsp_user_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge dsp_user_clk);
        #1;
    endtask

    task automatic clr();
        n_wr = 0;
        n_rd = 0;
    endtask

    // cfg_mgmt responder: completes each strobe lat cycles after it rises and records what was driven
    initial begin
        logic [1:0] key, prev;
        int cnt;
        prev = 2'b00;
        cnt = 0;
        forever begin
            @(posedge dsp_user_clk);
            #1;
            key = {wr, rd};
            done_in = 1'b0;
            if (&key) both_seen = 1'b1;
            if (prev[1] && !key[1]) last_wlen = wlen;
            wlen = key[1] ? wlen + 1 : 0;
            if (key != prev && key != 2'b00) begin
                cnt = 0;
                if (key[1]) begin
                    n_wr++;
                    last_wdata = wdata;
                    last_be = be;
                    last_addr = addr;
                    last_fn = fn;
                end
                if (key[0]) begin
                    n_rd++;
                    last_rd_be = be;
                end
            end
            if (key != 2'b00) begin
                cnt++;
                if (rsp_en && cnt == lat) begin
                    done_in = 1'b1;
                    if (key[0]) read_data = (rdq.size() > 0) ? {24'h0, rdq.pop_front()} : {24'h0, rd_def};
                end
            end
            prev = key;
        end
    end

    initial begin
        sys_reset_n = 1'b0;
        rdy = 1'b0;
        sec = 8'h00;
        wb_gnt = 1'b0;
        done_in = 1'b0;
        read_data = 32'h0;
        rsp_en = 1'b1;
        lat = 3;
        rd_def = 8'h00;
        clr();
        #3;
        check("rst_outs", 64'(|all_outs), 64'd0);
        repeat (2) @(posedge dsp_user_clk);
        #1 sys_reset_n = 1'b1;
        tick();

        clr();
        rd_def = 8'h05;
        sec = 8'h05;
        wb_gnt = 1'b1;
        rdy = 1'b1;
        cyc = 0;
        while (!writeback_done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("t1_latency", 64'(cyc), 64'd9);
        check("t1_done", 64'(writeback_done), 64'd1);
        check("t1_err", 64'(writeback_error), 64'd0);
        check("t1_writes", 64'(n_wr), 64'd1);
        check("t1_reads", 64'(n_rd), 64'd1);
        check("t1_wdata", 64'(last_wdata), 64'h05);
        check("t1_be", 64'(last_be), 64'h1);
        check("t1_addr", 64'(last_addr), 64'h6);
        check("t1_fn", 64'(last_fn), 64'h3);
        check("t1_rd_be", 64'(last_rd_be), 64'h0);
        check("t1_req", 64'(wb_req), 64'd0);

        clr();
        rd_def = 8'h09;
        sec = 8'h09;
        tick();
        check("t4_done_clr", 64'(writeback_done), 64'd0);
        check("t4_req", 64'(wb_req), 64'd1);
        for (int i = 0; i < 100 && !writeback_done; i++) tick();
        check("t4_done", 64'(writeback_done), 64'd1);
        check("t4_writes", 64'(n_wr), 64'd1);
        check("t4_wdata", 64'(last_wdata), 64'h09);

        clr();
        rd_def = 8'h0A;
        rdq.push_back(8'h00);
        rdq.push_back(8'h00);
        sec = 8'h0A;
        tick();
        for (int i = 0; i < 200 && !writeback_done; i++) tick();
        check("t2_done", 64'(writeback_done), 64'd1);
        check("t2_writes", 64'(n_wr), 64'd3);
        check("t2_reads", 64'(n_rd), 64'd3);
        check("t2_err", 64'(writeback_error), 64'd0);

        clr();
        rsp_en = 1'b0;
        sec = 8'h0B;
        for (int i = 0; i < 300 && !writeback_error; i++) tick();
        check("t3_err", 64'(writeback_error), 64'd1);
        check("t3_writes", 64'(n_wr), 64'd4);
        check("t3_reads", 64'(n_rd), 64'd0);
        check("t3_wlen", 64'(last_wlen), 64'd16);
        check("t3_req", 64'(wb_req), 64'd0);
        check("t3_done", 64'(writeback_done), 64'd0);
        repeat (5) tick();
        check("t3_err_sticky", 64'(writeback_error), 64'd1);
        check("t3_no_more", 64'(n_wr), 64'd4);

        clr();
        rsp_en = 1'b1;
        rd_def = 8'h0C;
        sec = 8'h0C;
        tick();
        check("t5_err_clr", 64'(writeback_error), 64'd0);
        for (int i = 0; i < 50 && !rd; i++) tick();
        check("t5_read_seen", 64'(rd), 64'd1);
        rdy = 1'b0;
        repeat (10) tick();
        check("t5_writes", 64'(n_wr), 64'd1);
        check("t5_reads", 64'(n_rd), 64'd1);
        check("t5_done", 64'(writeback_done), 64'd0);
        check("t5_req", 64'(wb_req), 64'd0);
        check("t5_read_off", 64'(rd), 64'd0);

        clr();
        rdy = 1'b1;
        for (int i = 0; i < 50 && !wr; i++) tick();
        check("t6_write_seen", 64'(wr), 64'd1);
        #2 sys_reset_n = 1'b0;
        #1 check("t6_async_rst", 64'(|all_outs), 64'd0);
        repeat (2) @(posedge dsp_user_clk);
        #1 sys_reset_n = 1'b1;
        clr();
        for (int i = 0; i < 100 && !writeback_done; i++) tick();
        check("t6_done", 64'(writeback_done), 64'd1);
        check("t6_writes", 64'(n_wr), 64'd1);
        check("t6_wdata", 64'(last_wdata), 64'h0C);

        check("one_strobe", 64'(both_seen), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
